// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports, two prioritised
// write ports, optional write-to-read bypass, optional hard-wired zero entry,
// and a one-entry-per-cycle clear sweep that zeroes the array without a reset.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NREAD*ADDR_W-1:0]   i_raddr,
  output logic [NREAD*DATA_W-1:0]   o_rdata,
  input  logic                      i_wen0,
  input  logic [ADDR_W-1:0]         i_waddr0,
  input  logic [DATA_W-1:0]         i_wdata0,
  input  logic                      i_wen1,
  input  logic [ADDR_W-1:0]         i_waddr1,
  input  logic [DATA_W-1:0]         i_wdata1,
  input  logic                      i_clr_req,
  output logic                      o_clr_busy,
  output logic                      o_clr_done
);

  localparam int unsigned         DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]   CNT_LAST   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]   CNT_PENULT = ADDR_W'(DEPTH - 2);

  typedef enum logic {StIdle, StClear} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_we0;
  logic                w_we1;
  logic [ADDR_W-1:0]   w_ra;
  logic [DATA_W-1:0]   w_rd;

  // Writes aimed at the zero entry are dropped when it is hard-wired.
  assign w_we0 = i_wen0 && !((ZERO_REG != 0) && (i_waddr0 == '0));
  assign w_we1 = i_wen1 && !((ZERO_REG != 0) && (i_waddr1 == '0));

  assign o_clr_busy = r_busy;
  assign o_clr_done = r_done;

  // Array update: sweep clear first, then port 0, then port 1, so the last
  // non-blocking assignment to an entry wins (port 1 > port 0 > sweep).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (r_state == StClear) begin
        r_mem[r_cnt] <= '0;
      end
      if (w_we0) begin
        r_mem[i_waddr0] <= i_wdata0;
      end
      if (w_we1) begin
        r_mem[i_waddr1] <= i_wdata1;
      end
    end
  end

  // Clear sweep FSM; busy/done are registered and line up with the sweep cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (i_clr_req) begin
            r_state <= StClear;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        StClear: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            // Done is high during the cycle in which the last entry is cleared.
            r_done <= (r_cnt == CNT_PENULT);
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational read ports with optional bypass; the zero entry overrides all.
  always_comb begin
    o_rdata = '0;
    w_ra    = '0;
    w_rd    = '0;
    for (int k = 0; k < int'(NREAD); k++) begin
      w_ra = i_raddr[k*ADDR_W +: ADDR_W];
      w_rd = r_mem[w_ra];
      if (BYPASS != 0) begin
        if (i_wen1 && (i_waddr1 == w_ra)) begin
          w_rd = i_wdata1;
        end else if (i_wen0 && (i_waddr0 == w_ra)) begin
          w_rd = i_wdata0;
        end
      end
      if ((ZERO_REG != 0) && (w_ra == '0)) begin
        w_rd = '0;
      end
      o_rdata[k*DATA_W +: DATA_W] = w_rd;
    end
  end

endmodule
